// File: rtl/accum_pkg.sv
// Shared types for the serial accumulator: operation codes and FSM states.
package accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/select_slice.sv
// Combinational carry-select slice: both carry-in cases are summed up front
// and the real carry-in only drives the final mux.
module select_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] sum0;
  logic [WIDTH:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};

  assign {cout, s} = cin ? sum1 : sum0;

endmodule

// File: rtl/serial_accum_unit.sv
// Accumulator with add/sub/load/clear. Add and subtract are computed one
// slice per cycle through a single reused carry-select slice; acc_q only
// changes on the completion edge so partial sums are never visible.
module serial_accum_unit
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] acc_q,
  output logic                  carry_q,
  output logic                  ovf_q
);

  localparam int NSLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_e                  state;
  state_e                  state_nxt;
  op_e                     op_in;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [DATA_WIDTH-1:0]   res_reg;
  logic [DATA_WIDTH-1:0]   res_nxt;
  logic                    cin_reg;
  logic [SLICE_WIDTH-1:0]  a_sl;
  logic [SLICE_WIDTH-1:0]  b_sl;
  logic [SLICE_WIDTH-1:0]  s_sl;
  logic                    cout_sl;

  assign op_in = op_e'(op);

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b,
                                   input logic signed [DATA_WIDTH-1:0] r);
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  // Select the operand chunks for the current slice index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICES; k++) begin
      if (idx == IDX_W'(k)) begin
        a_sl = a_reg[k*SLICE_WIDTH +: SLICE_WIDTH];
        b_sl = b_reg[k*SLICE_WIDTH +: SLICE_WIDTH];
      end
    end
  end

  select_slice #(
    .WIDTH(SLICE_WIDTH)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .cin (cin_reg),
    .s   (s_sl),
    .cout(cout_sl)
  );

  // Merge this cycle's slice sum into the shadow result.
  always_comb begin
    res_nxt = res_reg;
    for (int k = 0; k < NSLICES; k++) begin
      if (idx == IDX_W'(k)) begin
        res_nxt[k*SLICE_WIDTH +: SLICE_WIDTH] = s_sl;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (op_in == OP_ADD || op_in == OP_SUB) state_nxt = RUN;
          else                                    state_nxt = DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, slice stepping and accumulator/flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cin_reg <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op_in)
              OP_ADD: begin
                a_reg   <= acc_q;
                b_reg   <= operand_i;
                cin_reg <= 1'b0;
                idx     <= '0;
              end
              OP_SUB: begin
                // Subtract as acc + ~operand + 1.
                a_reg   <= acc_q;
                b_reg   <= ~operand_i;
                cin_reg <= 1'b1;
                idx     <= '0;
              end
              OP_LOAD: begin
                acc_q   <= operand_i;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
              end
              OP_CLR: begin
                acc_q   <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          res_reg <= res_nxt;
          cin_reg <= cout_sl;
          if (idx == LAST_IDX) begin
            acc_q   <= res_nxt;
            carry_q <= cout_sl;
            ovf_q   <= add_ovf(a_reg, b_reg, res_nxt);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_accum_unit.sv
// Randomised self-checking bench for serial_accum_unit at three widths,
// compared against an arithmetic reference model.
module tb_serial_accum_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [3];
  logic [1:0]  op_s    [3];
  logic [31:0] opnd_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        carry_s [3];
  logic        ovf_s   [3];
  logic [15:0] acc16;
  logic [7:0]  acc8;
  logic [31:0] acc32;

  longint acc_m   [3];
  longint carry_m [3];
  longint ovf_m   [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_accum_unit #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) u16 (
    .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]),
    .operand_i(opnd_s[0][15:0]), .busy(busy_s[0]), .done(done_s[0]),
    .acc_q(acc16), .carry_q(carry_s[0]), .ovf_q(ovf_s[0]));

  serial_accum_unit #(.DATA_WIDTH(8), .SLICE_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]),
    .operand_i(opnd_s[1][7:0]), .busy(busy_s[1]), .done(done_s[1]),
    .acc_q(acc8), .carry_q(carry_s[1]), .ovf_q(ovf_s[1]));

  serial_accum_unit #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) u32 (
    .clk(clk), .reset(reset), .start(start_s[2]), .op(op_s[2]),
    .operand_i(opnd_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .acc_q(acc32), .carry_q(carry_s[2]), .ovf_q(ovf_s[2]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int w_of(input int u);
    return (u == 0) ? 16 : (u == 1) ? 8 : 32;
  endfunction

  function automatic int n_of(input int u);
    return (u == 0) ? 4 : (u == 1) ? 1 : 4;
  endfunction

  function automatic longint acc_of(input int u);
    return (u == 0) ? longint'(acc16) : (u == 1) ? longint'(acc8) : longint'(acc32);
  endfunction

  function automatic longint to_signed(input longint v, input int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Reference: plain wide arithmetic, signed range check for overflow.
  task automatic model(input int u, input logic [1:0] o, input logic [31:0] v);
    int     w;
    longint mask, a, b, full, ss;
    w    = w_of(u);
    mask = (longint'(1) << w) - 1;
    a    = acc_m[u];
    b    = longint'(v) & mask;
    case (o)
      2'b00: begin
        full = a + b;
        ss   = to_signed(a, w) + to_signed(b, w);
        acc_m[u]   = full & mask;
        carry_m[u] = (full >> w) & 1;
        ovf_m[u]   = (ss > (longint'(1) << (w - 1)) - 1 || ss < -(longint'(1) << (w - 1))) ? 1 : 0;
      end
      2'b01: begin
        full = a + ((~b) & mask) + 1;
        ss   = to_signed(a, w) - to_signed(b, w);
        acc_m[u]   = full & mask;
        carry_m[u] = (full >> w) & 1;
        ovf_m[u]   = (ss > (longint'(1) << (w - 1)) - 1 || ss < -(longint'(1) << (w - 1))) ? 1 : 0;
      end
      2'b10: begin
        acc_m[u] = b; carry_m[u] = 0; ovf_m[u] = 0;
      end
      default: begin
        acc_m[u] = 0; carry_m[u] = 0; ovf_m[u] = 0;
      end
    endcase
  endtask

  // Issue one operation, optionally pulse a stray start during RUN, and
  // check handshake timing and the final result.
  task automatic run_op(input int u, input logic [1:0] o, input logic [31:0] v, input bit inj);
    int n, nb, nd, dpos, exp_b, exp_d;
    n = n_of(u);
    @(negedge clk);
    start_s[u] = 1'b1; op_s[u] = o; opnd_s[u] = v;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0; op_s[u] = 2'($urandom); opnd_s[u] = $urandom;
    model(u, o, v);
    nb = 0; nd = 0; dpos = 0;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (inj && k == 2) begin start_s[u] = 1'b1; op_s[u] = 2'b00; opnd_s[u] = 32'h0F00; end
      if (inj && k == 3) start_s[u] = 1'b0;
      if (busy_s[u]) nb++;
      if (done_s[u]) begin nd++; dpos = k; end
    end
    exp_b = (o[1] == 1'b0) ? n : 0;
    exp_d = (o[1] == 1'b0) ? n + 1 : 1;
    check("busy_cycles", nb, exp_b);
    check("done_count", nd, 1);
    check("done_pos", dpos, exp_d);
    check("acc", acc_of(u), acc_m[u]);
    check("carry", longint'(carry_s[u]), carry_m[u]);
    check("ovf", longint'(ovf_s[u]), ovf_m[u]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int u = 0; u < 3; u++) begin acc_m[u] = 0; carry_m[u] = 0; ovf_m[u] = 0; end
  endtask

  initial begin
    int nd;
    logic [1:0] o;
    reset = 1'b0;
    for (int u = 0; u < 3; u++) begin start_s[u] = 1'b0; op_s[u] = 2'b00; opnd_s[u] = '0; end
    do_reset();
    for (int u = 0; u < 3; u++) begin
      check("rst_acc", acc_of(u), 0);
      check("rst_carry", longint'(carry_s[u]), 0);
      check("rst_ovf", longint'(ovf_s[u]), 0);
      check("rst_busy", longint'(busy_s[u]), 0);
      check("rst_done", longint'(done_s[u]), 0);
    end

    // Directed sequences on the 16-bit unit.
    run_op(0, 2'b00, 32'h1234, 1'b0);
    check("add_1234", acc_of(0), 64'h1234);
    run_op(0, 2'b10, 32'hFFFF, 1'b0);
    run_op(0, 2'b00, 32'h0001, 1'b0);
    check("wrap_acc", acc_of(0), 0);
    check("wrap_carry", longint'(carry_s[0]), 1);
    run_op(0, 2'b10, 32'h7FFF, 1'b0);
    run_op(0, 2'b00, 32'h0001, 1'b0);
    check("pos_ovf", longint'(ovf_s[0]), 1);
    run_op(0, 2'b10, 32'h0005, 1'b0);
    run_op(0, 2'b01, 32'h0007, 1'b0);
    check("sub_borrow_acc", acc_of(0), 64'hFFFE);
    check("sub_borrow_carry", longint'(carry_s[0]), 0);
    run_op(0, 2'b10, 32'h8000, 1'b0);
    run_op(0, 2'b01, 32'h0001, 1'b0);
    check("neg_ovf_acc", acc_of(0), 64'h7FFF);
    check("neg_ovf_flag", longint'(ovf_s[0]), 1);
    run_op(0, 2'b10, 32'h0001, 1'b0);
    run_op(0, 2'b00, 32'h0010, 1'b1);
    check("ignored_start", acc_of(0), 64'h0011);
    run_op(0, 2'b11, 32'h5555, 1'b0);
    check("clr_acc", acc_of(0), 0);

    // Reset while the 16-bit unit is at slice index 2.
    run_op(0, 2'b10, 32'h0100, 1'b0);
    @(negedge clk);
    start_s[0] = 1'b1; op_s[0] = 2'b00; opnd_s[0] = 32'h0022;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int u = 0; u < 3; u++) begin acc_m[u] = 0; carry_m[u] = 0; ovf_m[u] = 0; end
    check("midrst_acc", acc_of(0), 0);
    check("midrst_busy", longint'(busy_s[0]), 0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_s[0]) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", nd, 0);
    run_op(0, 2'b00, 32'h00AB, 1'b0);
    check("after_rst_add", acc_of(0), 64'h00AB);

    // Single-slice 8-bit unit.
    run_op(1, 2'b10, 32'h80, 1'b0);
    run_op(1, 2'b00, 32'h80, 1'b0);
    check("w8_acc", acc_of(1), 0);
    check("w8_carry", longint'(carry_s[1]), 1);
    check("w8_ovf", longint'(ovf_s[1]), 1);

    // Random traffic on the 32-bit and 16-bit units.
    for (int i = 0; i < 40; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 2'($urandom) : {1'b0, 1'($urandom)};
      run_op(2, o, $urandom, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      o = ($urandom_range(0, 7) == 0) ? 2'b10 : {1'b0, 1'($urandom)};
      run_op(0, o, $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_accum_unit.md
Name: serial_accum_unit

Overview:
- Parametrised successor to the lab's 17-bit run-button accumulator.
- Accumulator of DATA_WIDTH bits with four operations: add, subtract, load, clear. Provides carry and signed-overflow flags.
- Add/sub runs through a carry-select slice adder one SLICE_WIDTH chunk per cycle, with a start/busy/done handshake.
- Sits between the button edge detector (start pulse) plus the synchronised switches, and the hex display/LED outputs.

Parameters:
- DATA_WIDTH, 16: accumulator and operand width. Must be a multiple of SLICE_WIDTH.
- SLICE_WIDTH, 4: bits added per cycle. NSLICES = DATA_WIDTH/SLICE_WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  single-cycle request pulse; sampled only in IDLE.
- op  in  2  operation, captured with start (encoding in package).
- operand_i  in  DATA_WIDTH  operand, captured with start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse after the operation completes.
- acc_q  out  DATA_WIDTH  accumulator value.
- carry_q  out  1  ADD: carry out of the MSB. SUB: not-borrow. LOAD/CLR: 0.
- ovf_q  out  1  signed two's-complement overflow of the last add/sub. LOAD/CLR: 0.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. Reset has priority over everything, in any state. After the reset edge: state IDLE, acc_q=0, carry_q=0, ovf_q=0, busy=0, done=0, slice index=0, shadow registers=0.
- Encoding: OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_CLR=2'b11.
- State machine has three states, IDLE, RUN and DONE; next-state rules are below.
- IDLE, start=1, op ADD/SUB:
  - b_reg <= operand_i (ADD) or ~operand_i (SUB).
  - cin_reg <= 0 (ADD) or 1 (SUB).
  - a_reg <= acc_q; idx <= 0; go to RUN.
- IDLE, start=1, op LOAD/CLR:
  - On the same edge, acc_q <= operand_i (LOAD) or 0 (CLR); carry_q <= 0; ovf_q <= 0.
  - Go to DONE.
- RUN, each cycle:
  - Slice idx of a_reg + b_reg + cin_reg is written into result shadow slice idx; cin_reg <= slice carry-out.
  - When idx == NSLICES-1, on that edge: acc_q <= full result; carry_q <= final carry-out; ovf_q <= (a_msb == b_msb) && (result_msb != a_msb), using the (possibly inverted) b_reg MSB. Go to DONE.
  - Otherwise idx <= idx+1.
- acc_q never shows partial sums; it changes only on the completion edge.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency from the start sampling edge E0:
  - ADD/SUB: acc_q updates at edge E(NSLICES); done is high in the cycle after it. busy is high for NSLICES cycles.
  - LOAD/CLR: acc_q updates at E0; done is high in the next cycle; busy stays 0.
- start while busy or in DONE: ignored. No queueing, and op/operand_i are not re-captured.
- operand_i may change after the start edge without effect.
- Reset mid-RUN: the operation is aborted and acc_q=0; there is no done pulse.
- Wrap-around: the result is modulo 2^DATA_WIDTH; carry and ovf report it.
- Back-to-back: the earliest next accepted start is the cycle after DONE, i.e. in IDLE.

Decomposition:
- Package accum_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_LOAD, OP_CLR).
  - state_e enum (IDLE, RUN, DONE).
- Sub-module select_slice:
  - Combinational SLICE_WIDTH-bit carry-select slice: two precomputed sums for cin=0/1, muxed by cin.
  - Inputs a, b, cin; outputs s, cout. Parameter WIDTH.
  - Instantiated once and reused across cycles.

Test Plan:
- Reset, then start ADD operand 0x1234 → busy high 4 cycles; acc_q=0x1234, carry=0, ovf=0; one done pulse 5 cycles after the start edge.
- LOAD 0xFFFF (done next cycle, busy never high), then ADD 0x0001 → acc_q=0x0000, carry=1, ovf=0. LOAD 0x7FFF, ADD 0x0001 → 0x8000, carry=0, ovf=1.
- LOAD 0x0005, SUB 0x0007 → 0xFFFE, carry=0 (borrow), ovf=0. LOAD 0x8000, SUB 0x0001 → 0x7FFF, carry=1, ovf=1.
- Start ADD 0x0010 from acc 0x0001, pulse start again with 0x0F00 during RUN → ignored; acc_q=0x0011 and a single done. Then CLR → acc_q=0, flags 0.
- ADD in progress, reset at RUN idx=2 → next cycle acc_q=0, busy=0, no done. A subsequent ADD 0x00AB → 0x00AB.
- DATA_WIDTH=8, SLICE_WIDTH=8: ADD 0x80 to 0x80 → 0x00, carry=1, ovf=1; busy 1 cycle, done 2 cycles after start. Also DATA_WIDTH=32, SLICE_WIDTH=8: random add/sub checked against a reference model.
